// File: rtl/always_demux_pkg.sv
// Shared sizing constants for the always_demux slice.
// Optional feature macro: ROUTE_CNT_EN (per-channel accept counters).
package always_demux_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_SEL_W  = 2;
    localparam int CNT_W      = 8;

    // Number of output channels addressed by a select of the given width.
    function automatic int nch_of(input int sel_w);
        return 1 << sel_w;
    endfunction

endpackage

// File: rtl/always_demux_slot.sv
// Single-entry channel buffer: data register plus valid flag.
// A load always wins over a drain in the same cycle, so a word that arrives
// while the previous one is being consumed keeps the channel valid.
module always_demux_slot #(
    parameter int DATA_W = always_demux_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    // Valid flag: set on load, cleared on drain, load takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Data register: changes only when a new word is loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end
    end

endmodule

// File: rtl/always_demux.sv
// Registered 1-to-NCH demultiplexer with a single-entry buffer per channel.
// Optional feature macro: ROUTE_CNT_EN adds route_cnt, a saturating 8-bit
// accept counter per channel packed as channel i in [i*8 +: 8].
module always_demux
    import always_demux_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int SEL_W  = DEF_SEL_W,
    localparam int NCH    = nch_of(SEL_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     din,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NCH*DATA_W-1:0] dout,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready
`ifdef ROUTE_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0]  route_cnt
`endif
);

    logic           accept;
    logic [NCH-1:0] load_vec;
    logic [NCH-1:0] drain_vec;

    // Target channel can take a word if empty or draining this cycle;
    // nothing is accepted while reset is held.
    always_comb begin
        in_ready = !reset && (!out_valid[sel] || out_ready[sel]);
        accept   = in_valid && in_ready;
    end

    // One-hot load strobe for the selected channel.
    always_comb begin
        load_vec = '0;
        if (accept) begin
            load_vec[sel] = 1'b1;
        end
    end

    // Each channel drains independently of the one being loaded.
    always_comb begin
        drain_vec = out_valid & out_ready;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        always_demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load_vec[i]),
            .drain (drain_vec[i]),
            .din   (din),
            .data  (dout[i*DATA_W +: DATA_W]),
            .valid (out_valid[i])
        );
    end

`ifdef ROUTE_CNT_EN
    for (genvar i = 0; i < NCH; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;

        // Saturating per-channel accept counter.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (load_vec[i] && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign route_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_always_demux.sv
// Self-checking bench for always_demux against a queue-based reference model.
// Build with ROUTE_CNT_EN defined to also exercise the accept counters.
module tb_always_demux;

    localparam int DW  = 3;
    localparam int SW  = 2;
    localparam int NC  = 4;

    logic           clk;
    logic           reset;
    logic [DW-1:0]  din;
    logic [SW-1:0]  sel;
    logic           in_valid;
    logic           in_ready;
    logic [NC*DW-1:0] dout;
    logic [NC-1:0]  out_valid;
    logic [NC-1:0]  out_ready;
`ifdef ROUTE_CNT_EN
    logic [NC*8-1:0] route_cnt;
`endif

    int tests;
    int fails;

    // Reference model: words accepted but not yet consumed, per channel,
    // last word delivered per channel, and accept totals per channel.
    logic [DW-1:0] q [NC][$];
    logic [DW-1:0] last [NC];
    int            acc_cnt [NC];

    always_demux #(
        .DATA_W (DW),
        .SEL_W  (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef ROUTE_CNT_EN
        ,
        .route_cnt (route_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_clear();
        for (int c = 0; c < NC; c++) begin
            q[c].delete();
            last[c]    = '0;
            acc_cnt[c] = 0;
        end
    endfunction

    // Compare registered outputs against the model (called after an edge).
    task automatic check_outputs(input string name);
        logic [NC-1:0]    exp_ov;
        logic [NC*DW-1:0] exp_do;
        for (int c = 0; c < NC; c++) begin
            exp_ov[c]           = (q[c].size() != 0);
            exp_do[c*DW +: DW]  = last[c];
        end
        tests++;
        if (out_valid !== exp_ov) begin
            fails++;
            $display("FAIL %s out_valid: got %b expected %b", name, out_valid, exp_ov);
        end
        tests++;
        if (dout !== exp_do) begin
            fails++;
            $display("FAIL %s dout: got %h expected %h", name, dout, exp_do);
        end
    endtask

    // One clock of traffic. Entered 1 time unit after a rising edge.
    task automatic step(input logic v, input logic [SW-1:0] s,
                        input logic [DW-1:0] d, input logic [NC-1:0] ordy,
                        input string name, output logic accepted);
        logic exp_rdy;
        in_valid  = v;
        sel       = s;
        din       = d;
        out_ready = ordy;
        #2;
        exp_rdy = (q[s].size() == 0) || ordy[s];
        tests++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL %s in_ready: got %b expected %b", name, in_ready, exp_rdy);
        end
        // Consumers take the oldest outstanding word; it must be on dout now.
        for (int c = 0; c < NC; c++) begin
            if (q[c].size() != 0 && ordy[c]) begin
                tests++;
                if (dout[c*DW +: DW] !== q[c][0]) begin
                    fails++;
                    $display("FAIL %s consumed ch%0d: got %h expected %h",
                             name, c, dout[c*DW +: DW], q[c][0]);
                end
                void'(q[c].pop_front());
            end
        end
        accepted = v && exp_rdy;
        if (accepted) begin
            q[s].push_back(d);
            last[s] = d;
            acc_cnt[s]++;
        end
        @(posedge clk);
        #1;
        check_outputs(name);
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        sel       = 2'd1;
        din       = 3'h5;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_outputs("reset_hold");
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        #2;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        logic acc;
        for (int s = 0; s < NC; s++) begin
            step(1'b1, SW'(s), 3'h2, 4'hF, "sweep", acc);
            tests++;
            if (out_valid !== 4'(1 << s) || dout[s*DW +: DW] !== 3'h2) begin
                fails++;
                $display("FAIL sweep_ch%0d: got valid %b data %h expected valid %b data 2",
                         s, out_valid, dout[s*DW +: DW], 4'(1 << s));
            end
        end
        step(1'b0, 2'd0, 3'h0, 4'hF, "sweep_idle", acc);
    endtask

    task automatic test_stall();
        logic acc;
        step(1'b1, 2'd1, 3'h1, 4'h0, "stall_first", acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd1, 3'h6, 4'h0, "stall_wait", acc);
            tests++;
            if (acc !== 1'b0 || dout[DW +: DW] !== 3'h1) begin
                fails++;
                $display("FAIL stall_held: got accepted %b data %h expected 0 and 1",
                         acc, dout[DW +: DW]);
            end
        end
        step(1'b1, 2'd1, 3'h6, 4'h2, "stall_release", acc);
        tests++;
        if (out_valid[1] !== 1'b1 || dout[DW +: DW] !== 3'h6) begin
            fails++;
            $display("FAIL stall_deliver: got valid %b data %h expected 1 and 6",
                     out_valid[1], dout[DW +: DW]);
        end
        step(1'b0, 2'd0, 3'h0, 4'hF, "stall_flush", acc);
    endtask

    task automatic test_pass_through();
        logic acc;
        step(1'b1, 2'd2, 3'h5, 4'h0, "pt_fill", acc);
        step(1'b1, 2'd2, 3'h3, 4'h4, "pt_swap", acc);
        tests++;
        if (acc !== 1'b1 || out_valid[2] !== 1'b1 || dout[2*DW +: DW] !== 3'h3) begin
            fails++;
            $display("FAIL pass_through: got acc %b valid %b data %h expected 1 1 3",
                     acc, out_valid[2], dout[2*DW +: DW]);
        end
        step(1'b0, 2'd0, 3'h0, 4'hF, "pt_flush", acc);
    endtask

    task automatic test_reset_mid();
        logic acc;
        step(1'b1, 2'd0, 3'h7, 4'h0, "mid_fill0", acc);
        step(1'b1, 2'd3, 3'h4, 4'h0, "mid_fill3", acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 4'b0000 || dout !== '0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got valid %b dout %h in_ready %b expected 0 0 0",
                     out_valid, dout, in_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 3'h0, 4'hF, "post_reset_idle", acc);
        end
    endtask

    task automatic test_random();
        logic          acc;
        logic          v;
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        logic          hold;
        hold = 1'b0;
        s    = '0;
        d    = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                v = ($urandom_range(3) != 0);
                s = SW'($urandom_range(NC - 1));
                d = DW'($urandom);
            end
            step(v, s, d, NC'($urandom), "random", acc);
            hold = v && !acc;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 2'd0, 3'h0, 4'hF, "random_flush", acc);
        end
    endtask

`ifdef ROUTE_CNT_EN
    task automatic test_route_cnt();
        logic acc;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'd0, DW'(i), 4'hF, "cnt_load", acc);
        end
        for (int c = 0; c < NC; c++) begin
            int exp_c;
            exp_c = (acc_cnt[c] > 255) ? 255 : acc_cnt[c];
            tests++;
            if (route_cnt[c*8 +: 8] !== 8'(exp_c)) begin
                fails++;
                $display("FAIL route_cnt_ch%0d: got %0d expected %0d",
                         c, route_cnt[c*8 +: 8], exp_c);
            end
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        model_clear();
        test_reset();
        test_sweep();
        test_stall();
        test_pass_through();
        test_reset_mid();
        test_random();
`ifdef ROUTE_CNT_EN
        test_route_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/always_demux.md
ALWAYS_DEMUX -- requirements
Module: always_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 3, data word width.
REQ-002 SHALL have parameter SEL_W, default 2, select width; channel count NCH = 2**SEL_W (4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port din  input  DATA_W  input word.
REQ-006 SHALL have port sel  input  SEL_W  destination channel of din.
REQ-007 SHALL have port in_valid  input  1  din/sel valid.
REQ-008 SHALL have port in_ready  output  1  word accepted this cycle when in_valid=1.
REQ-009 SHALL have port dout  output  NCH*DATA_W  channel i data in bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  NCH  per-channel valid.
REQ-011 SHALL have port out_ready  input  NCH  per-channel consumer ready.

Function
REQ-012 SHALL hold one single-entry buffer per channel (data register + valid flag).
REQ-013 SHALL drive in_ready = !out_valid[sel] | out_ready[sel] (combinational; pass-through when target drains same cycle).
REQ-014 SHALL, on accept (in_valid & in_ready), load din into channel sel and set out_valid[sel] at the next edge; latency 1 cycle.
REQ-015 SHALL, on drain (out_valid[i] & out_ready[i]), clear out_valid[i] at next edge unless channel i is loaded the same cycle, in which case out_valid[i] stays 1 and dout[i] takes the new word.
REQ-016 SHALL let non-target channels drain independently while a different channel is loaded.
REQ-017 SHALL hold dout[i] at its last loaded value after drain; dout[i] changes only on load.
REQ-018 SHALL never drop or duplicate a word; every accepted word appears exactly once on its channel.
REQ-019 SHALL ignore din/sel when in_valid=0; initiator holds din/sel stable while in_valid=1 & in_ready=0.
REQ-020 SHALL keep in_ready combinationally independent of din.

Reset
REQ-021 SHALL, on reset=1 (asynchronous), clear all out_valid to 0 and all dout to 0 immediately.
REQ-022 SHALL discard buffered words on reset mid-operation; no accept occurs while reset=1 (in_ready forced 0).
REQ-023 SHALL resume accepting on the first rising edge after reset deasserts.

Configuration
REQ-024 SHALL, with ROUTE_CNT_EN defined, add output route_cnt (NCH*8 bits): per-channel accept count, reset 0, +1 per accept to that channel, saturating at 255.
REQ-025 SHALL, without ROUTE_CNT_EN, omit route_cnt and all counter logic; other behaviour identical.

Structure
REQ-026 SHALL take DATA_W/SEL_W defaults, NCH and counter width from shared package always_demux_pkg.
REQ-027 SHALL implement one channel buffer as sub-module always_demux_slot (load, drain, data, valid), instantiated NCH times.

Verification
REQ-028 SHALL check: reset=1 for 2 clocks -> out_valid=4'b0000, dout=0, in_ready=0; after release in_ready=1.
REQ-029 SHALL check: din=3'h2, sel=0..3 in successive cycles, out_ready=4'hF -> each out_valid[sel] pulses one cycle after accept with dout[sel]=3'h2.
REQ-030 SHALL check: out_ready=0, din=3'h1 sel=1 then din=3'h6 sel=1 -> first accepted, second stalls (in_ready=0) until out_ready[1]=1, then 3'h6 delivered next cycle.
REQ-031 SHALL check: channel 2 full, out_ready[2]=1 and new din=3'h3 sel=2 same cycle -> accept, out_valid[2] stays 1, dout[2]=3'h3.
REQ-032 SHALL check: reset pulse while channels 0 and 3 hold data -> out_valid clears asynchronously, no word emitted after release.
REQ-033 SHALL check (ROUTE_CNT_EN): 300 accepts to channel 0 -> route_cnt[0]=255, others 0.
